node_seq_mac: RTL
=================

Name: node_seq_mac

Overview:
- Parametrised, time-multiplexed successor to the fully unrolled per-neuron float32 nodes.
- Computes one neuron: out = ACT(sum over k of A[k]*W[k] + B), in IEEE-754 single precision.
- Uses one float_mult and one float_adder with a registered accumulator instead of N multipliers and an adder tree.
- Weights and bias sit in a runtime-loadable register file. Inputs stream in with valid/ready; the result leaves on a valid/ready output.

Parameters:
- N_IN, 30, number of inputs/weights per neuron (legal range 1..1024).
- ACT, 1, activation: 0 = identity, 1 = ReLU (sign bit set -> 32'd0).
- AW, $clog2(N_IN+1), weight-file address width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- w_we  in  1  weight/bias write strobe.
- w_addr  in  AW  0..N_IN-1 selects W[k]; N_IN selects bias B.
- w_data  in  32  float32 weight/bias value.
- w_err  out  1  one-cycle pulse: write dropped (busy or address > N_IN).
- in_valid  in  1  input element valid.
- in_ready  out  1  block accepts an input element.
- in_data  in  32  float32 activation A[k], presented in order k = 0..N_IN-1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  32  float32 neuron output.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, on rst high):
  - state = IDLE, k = 0, acc = 0, out_data = 0, out_valid = 0, w_err = 0.
  - Weight file and B reset to 32'd0.
- States: IDLE, ACC, BIAS, HOLD.
- in_ready = 1 in IDLE and ACC; 0 in BIAS and HOLD.
- An element is accepted on a rising edge where in_valid && in_ready.
- IDLE:
  - On accept: acc <= fmul(in_data, W[0]) (not added to the old acc), k <= 1.
  - Next state is ACC, or BIAS if N_IN == 1.
- ACC:
  - On accept: acc <= fadd(acc, fmul(in_data, W[k])), k <= k+1.
  - On accepting the element with k == N_IN-1, go to BIAS and set k <= 0.
  - No accept: hold all state.
- BIAS (exactly one cycle):
  - s = fadd(acc, B).
  - out_data <= (ACT==1 && s[31]) ? 32'd0 : s, so -0.0 and negative NaN both give 0.
  - out_valid <= 1; next state HOLD.
- HOLD:
  - out_data and out_valid stay stable while out_ready is low.
  - On out_valid && out_ready: out_valid <= 0, state <= IDLE.
  - in_ready stays 0 until the next cycle (no same-cycle accept of the next vector).
- Latency: with the first accept at edge t0 and an unstalled stream, out_valid rises at edge t0+N_IN.
  - Throughput is one vector per N_IN+2 cycles when out_ready is held high.
- Weight writes:
  - Applied on the clock edge only in IDLE and only when w_addr <= N_IN.
  - Otherwise the write is dropped and w_err pulses for one cycle.
  - A write and an input accept on the same IDLE edge: the product uses the old W[0]; the write still lands.
- Arithmetic rounding, denormal and overflow behaviour are exactly those of float_mult and float_adder. There is no extra rounding stage.
- rst asserted mid-vector or in HOLD: the partial sum is discarded and outputs return to reset values immediately. Weights are cleared, so the host reloads them.
- in_valid may drop between elements (gaps allowed); the element order is never reordered.

Test Plan:
- N_IN=4, ACT=1, no gaps:
  - Stimulus: W = {1.0, 2.0, 0.5, -1.0} (3F800000, 40000000, 3F000000, BF800000), B = 0.5 (3F000000); A = {1.0, 1.0, 2.0, 1.0}.
  - Required: out_data = 3.5 (40600000); out_valid rises 4 edges after the first accept.
- Same weights, A = {0, 0, 0, 3.0}:
  - Pre-activation sum = -2.5.
  - Required: out_data = 32'd0.
  - With ACT=0 the same stimulus gives C0200000.
- Backpressure:
  - Stimulus: out_ready low for 10 cycles after out_valid rises; in_valid held high throughout.
  - Required: out_data stable, in_ready = 0 for all 10 cycles, no input consumed. The next vector starts only after the handshake.
- Input gaps:
  - Stimulus: in_valid toggles 1,0,0,1,0,1,1 over the first 4 elements of case 1.
  - Required: result still 40600000; k advances only on accepts.
- Weight write while busy:
  - Stimulus: w_we in ACC with w_addr=0, w_data=40400000; also a write in IDLE with w_addr=5 (N_IN=4).
  - Required: w_err pulses once for each; W unchanged; result equals case 1.
- Reset mid-vector:
  - Stimulus: assert rst after 2 accepts, reload weights, send case 1.
  - Required: out_valid = 0 and busy = 0 asynchronously; the next result is exactly 40600000, with no residue from the partial sum.

Source files
------------

// File: rtl/node_seq_mac.sv
// Time-multiplexed float32 neuron: one multiplier and one adder fold N_IN
// streamed inputs against a loadable weight file, add the bias, apply ACT.

module float_mult (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic              sign;
  logic [7:0]        ea, eb;
  logic [22:0]       fa, fb;
  logic [47:0]       prod;
  logic [22:0]       mant;
  logic              g, st;
  logic [23:0]       mant_r;
  logic signed [9:0] e, e_r;

  assign sign     = a[31] ^ b[31];
  assign {ea, fa} = a[30:0];
  assign {eb, fb} = b[30:0];
  assign prod     = {1'b1, fa} * {1'b1, fb};

  always_comb begin
    // NOTE: combinational logic uses blocking '=' and assigns every output on
    // every path; a missed branch would infer a latch.
    if (prod[47]) begin
      mant = prod[46:24];
      g    = prod[23];
      st   = |prod[22:0];
    end else begin
      mant = prod[45:23];
      g    = prod[22];
      st   = |prod[21:0];
    end
    mant_r = {1'b0, mant} + {23'd0, g & (st | mant[0])};
    e      = $signed({2'b00, ea}) + $signed({2'b00, eb})
           + $signed({9'd0, prod[47]}) - 10'sd127;
    e_r    = e + $signed({9'd0, mant_r[23]});

    // Denormal inputs are treated as zero; underflow flushes to signed zero.
    if ((ea == 8'hFF && fa != '0) || (eb == 8'hFF && fb != '0) ||
        (ea == 8'hFF && eb == 8'h00) || (eb == 8'hFF && ea == 8'h00))
      y = 32'h7FC0_0000;
    else if (ea == 8'hFF || eb == 8'hFF) y = {sign, 8'hFF, 23'd0};
    else if (ea == 8'h00 || eb == 8'h00) y = {sign, 31'd0};
    else if (e_r >= 10'sd255)            y = {sign, 8'hFF, 23'd0};
    else if (e_r <= 10'sd0)              y = {sign, 31'd0};
    else                                 y = {sign, e_r[7:0], mant_r[22:0]};
  end
endmodule

module float_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic              sa, sb, sx, a_big, sticky, up;
  logic [7:0]        ea, eb, ex, ey, d;
  logic [22:0]       fa, fb;
  logic [26:0]       mx, my, sm, sm_s;
  logic [27:0]       sum;
  logic [4:0]        p, shift;
  logic [25:0]       norm;
  logic [23:0]       mant_r;
  logic signed [9:0] e, e_r;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;

  always_comb begin
    a_big = {ea, fa} >= {eb, fb};
    sx    = a_big ? sa : sb;
    ex    = a_big ? ea : eb;
    ey    = a_big ? eb : ea;
    mx    = a_big ? {1'b1, fa, 3'b000} : {1'b1, fb, 3'b000};
    my    = a_big ? {1'b1, fb, 3'b000} : {1'b1, fa, 3'b000};
    d     = ex - ey;
    if (d >= 8'd27) begin
      sm     = '0;
      sticky = 1'b1;
    end else begin
      sm     = my >> d;
      sticky = |(my & ((27'd1 << d) - 27'd1));
    end
    sm_s = sm | {26'd0, sticky};
    sum  = (sa == sb) ? {1'b0, mx} + {1'b0, sm_s} : {1'b0, mx} - {1'b0, sm_s};

    p = '0;
    for (int i = 0; i < 27; i++)
      if (sum[i]) p = 5'(i);
    shift = 5'd26 - p;

    // The hidden bit is dropped from norm; bits [2:0] are guard/round/sticky.
    if (sum[27]) begin
      norm = {sum[26:2], sum[1] | sum[0]};
      e    = $signed({2'b00, ex}) + 10'sd1;
    end else begin
      norm = sum[25:0] << shift;
      e    = $signed({2'b00, ex}) - $signed({5'd0, shift});
    end
    up     = norm[2] & ((|norm[1:0]) | norm[3]);
    mant_r = {1'b0, norm[25:3]} + {23'd0, up};
    e_r    = e + $signed({9'd0, mant_r[23]});

    if ((ea == 8'hFF && fa != '0) || (eb == 8'hFF && fb != '0) ||
        (ea == 8'hFF && eb == 8'hFF && sa != sb))
      y = 32'h7FC0_0000;
    else if (ea == 8'hFF)                 y = a;
    else if (eb == 8'hFF)                 y = b;
    else if (ea == 8'h00 && eb == 8'h00)  y = {sa & sb, 31'd0};
    else if (ea == 8'h00)                 y = b;
    else if (eb == 8'h00)                 y = a;
    else if (sum == '0)                   y = 32'd0;
    else if (e_r >= 10'sd255)             y = {sx, 8'hFF, 23'd0};
    else if (e_r <= 10'sd0)               y = {sx, 31'd0};
    else                                  y = {sx, e_r[7:0], mant_r[22:0]};
  end
endmodule

module node_seq_mac #(
  parameter int N_IN = 30,
  parameter int ACT  = 1,
  parameter int AW   = $clog2(N_IN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          w_we,
  input  logic [AW-1:0] w_addr,
  input  logic [31:0]   w_data,
  output logic          w_err,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          busy
);
  localparam logic [AW-1:0] LAST_K    = AW'(N_IN - 1);
  localparam logic [AW-1:0] BIAS_ADDR = AW'(N_IN);

  typedef enum logic [1:0] {IDLE, ACC, BIAS, HOLD} state_t;

  state_t        state;
  logic [AW-1:0] k;
  logic [31:0]   acc, bias;
  logic [31:0]   w_mem [N_IN];
  logic [31:0]   prod, add_b, sum;
  logic          accept;

  assign in_ready = (state == IDLE) || (state == ACC);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  // The single adder folds in products while accumulating and the bias at the end.
  assign add_b    = (state == BIAS) ? bias : prod;

  float_mult  u_mult (.a(in_data), .b(w_mem[k]), .y(prod));
  float_adder u_add  (.a(acc),     .b(add_b),    .y(sum));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      acc       <= '0;
      bias      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      w_err     <= 1'b0;
      // NOTE: the weight file is a register array cleared on reset, so it
      // cannot map onto RAM macros; a reset always demands a host reload.
      for (int i = 0; i < N_IN; i++) w_mem[i] <= '0;
    end else begin
      w_err <= 1'b0;
      if (w_we) begin
        if (state == IDLE && w_addr <= BIAS_ADDR) begin
          if (w_addr == BIAS_ADDR) bias <= w_data;
          else                     w_mem[w_addr] <= w_data;
        end else begin
          w_err <= 1'b1;
        end
      end

      case (state)
        IDLE: if (accept) begin
          acc   <= prod;
          k     <= (N_IN == 1) ? '0 : AW'(1);
          state <= (N_IN == 1) ? BIAS : ACC;
        end
        ACC: if (accept) begin
          acc <= sum;
          if (k == LAST_K) begin
            k     <= '0;
            state <= BIAS;
          end else begin
            k <= k + AW'(1);
          end
        end
        BIAS: begin
          out_data  <= (ACT == 1 && sum[31]) ? 32'd0 : sum;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
